board_draw_ctrl: RTL and testbench
==================================

Name: board_draw_ctrl

Overview:
- Sequences the tile drawer (47x52 pixel-counter/ROM-address generator) across the 9x9 Sudoku grid.
- Arbitrates between full-board redraw and single-cell redraw requests.
- Per cell: fetches the digit from board storage, starts one tile draw, offsets drawer coordinates to screen space, and banks the ROM address by digit.
- Sits between game logic/board memory and the VGA plot interface.

Parameters:
- CELL_W, 47, tile width in pixels; drawer x runs 0..CELL_W-1.
- CELL_H, 52, tile height; drawer y runs 0..CELL_H-1.
- ORG_X, 0, screen x of cell (0,0).
- ORG_Y, 6, screen y of cell (0,0).
- TILE_WORDS, 2444, ROM words per digit tile (CELL_W*CELL_H).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- full_req  in  1  request full-board redraw (level; sampled in IDLE)
- cell_req  in  1  request single-cell redraw (level; sampled in IDLE)
- req_row  in  4  row for cell_req, 0..8
- req_col  in  4  column for cell_req, 0..8
- req_ack  out  1  one-cycle pulse when a request is accepted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last tile of a job completes
- rd_row  out  4  board-memory read row
- rd_col  out  4  board-memory read column
- rd_digit  in  4  digit 0..9 (0 = blank tile), valid one cycle after rd_row/rd_col
- draw_enable  out  1  enable to tile drawer; low resets the drawer
- draw_done  in  1  drawer finished the tile
- draw_x  in  6  drawer x count
- draw_y  in  6  drawer y count
- draw_addr  in  16  drawer ROM address (includes the drawer's start offset of 2)
- plot  out  1  pixel write strobe
- vga_x  out  10  pixel x
- vga_y  out  9  pixel y
- rom_addr  out  16  tile ROM address

Behaviour:
- Reset values: busy=0, req_ack=0, done=0, draw_enable=0, plot=0, rd_row=0, rd_col=0, vga_x=0, vga_y=0, rom_addr=0; state IDLE.
- FSM states: IDLE, FETCH, LATCH, DRAW, RELEASE, NEXT.
- IDLE:
  - full_req has priority over cell_req when both are high.
  - full_req: row=col=0, mode=FULL, req_ack pulses, go to FETCH.
  - cell_req: latch req_row/req_col, mode=CELL, req_ack pulses, go to FETCH.
  - cell_req with row>8 or col>8: req_ack pulses, then done pulses the next cycle, no draw.
- FETCH: drive rd_row/rd_col from the current cell; go to LATCH.
- LATCH: register rd_digit. Values >9 are clamped to 0. Compute:
  - base_x = ORG_X + col*CELL_W
  - base_y = ORG_Y + row*CELL_H
  - Use shift-add or constant multiply; no divider.
  - Go to DRAW.
- DRAW:
  - draw_enable=1.
  - plot = ~draw_done.
  - vga_x = base_x + draw_x; vga_y = base_y + draw_y.
  - rom_addr = digit*TILE_WORDS + draw_addr, truncated to 16 bits.
  - On draw_done=1, go to RELEASE. That cycle has plot=0.
- RELEASE: draw_enable=0 for exactly one cycle so the drawer clears its counters and done flag; go to NEXT.
- NEXT:
  - CELL mode: done pulse, go to IDLE.
  - FULL mode: col increments. At col=8, col wraps to 0 and row increments. After (8,8): done pulse, go to IDLE. Otherwise go to FETCH.
- Cell order is row-major, 81 tiles per full job.
- Requests arriving while busy are ignored; requesters hold the level until req_ack.
- busy is high from the cycle after req_ack through the done-pulse cycle.
- plot is 0 in every state except DRAW.
- Reset asserted mid-job: immediate return to IDLE with all outputs at reset values. The drawer sees draw_enable=0 and self-clears.
- Address range: max 9*2444 + 2445 = 24441, fits 16 bits.

Optional Feature:
- Macro HILITE_EN.
- Defined:
  - Adds inputs sel_row[3:0] and sel_col[3:0].
  - When the current cell equals (sel_row, sel_col), the effective digit is digit+10 (ROM holds 20 tiles), selecting the highlighted tile.
  - Max address is 19*2444 + 2445 = 48881, still 16 bits.
  - sel is sampled in LATCH.
- Undefined: ports absent; digit is used as is.

Test Plan:
- Reset: resetn=0 mid-DRAW → next clk edge irrelevant, outputs immediately 0, state IDLE; after release, draw_enable stays 0.
- cell_req (row 2, col 3), rd_digit=5, ORG_Y=6:
  - req_ack 1 cycle.
  - First plot at vga_x=141, vga_y=110, rom_addr=12222.
  - Plot count matches draw_enable-high cycles minus the draw_done cycle.
  - done pulses once.
- full_req with all digits 0:
  - 81 DRAW/RELEASE sequences in row-major order.
  - Last tile base is (376, 422).
  - One done pulse; busy low the cycle after done.
- full_req and cell_req both high in IDLE → full job accepted; cell_req ignored until busy drops, then accepted with a second req_ack.
- cell_req at row 9, col 0 → req_ack, done next cycle, draw_enable never asserted.
- HILITE_EN, sel=(4,4), digit 7 at (4,4) → rom_addr base 41548 (17*2444) for that cell only; neighbouring cells use 7*2444=17108.

Source files
------------

// File: rtl/board_draw_ctrl_if.sv
// ---------------------------------------------------------------------------
// board_draw_ctrl_if
//
// Bundles every signal that the board draw controller exchanges with the
// rest of the system: the request/acknowledge handshake from game logic,
// the board-memory read port, the tile-drawer control/status lines and the
// VGA plot bus. Clock and reset stay outside the interface.
//
// Signal summary (direction seen from the controller, i.e. modport master):
//   full_req     in   1   request full-board redraw (level)
//   cell_req     in   1   request single-cell redraw (level)
//   req_row      in   4   row for cell_req, 0..8
//   req_col      in   4   column for cell_req, 0..8
//   req_ack      out  1   one-cycle pulse when a request is accepted
//   busy         out  1   high in every state except idle
//   done         out  1   one-cycle pulse when a job completes
//   rd_row       out  4   board-memory read row
//   rd_col       out  4   board-memory read column
//   rd_digit     in   4   digit 0..9, valid one cycle after rd_row/rd_col
//   draw_enable  out  1   tile drawer enable; low clears the drawer
//   draw_done    in   1   drawer finished the tile
//   draw_x       in   6   drawer x count
//   draw_y       in   6   drawer y count
//   draw_addr    in   16  drawer ROM address
//   plot         out  1   pixel write strobe
//   vga_x        out  10  pixel x
//   vga_y        out  9   pixel y
//   rom_addr     out  16  tile ROM address
//   sel_row      in   4   highlighted cell row    (HILITE_EN only)
//   sel_col      in   4   highlighted cell column (HILITE_EN only)
//
// Optional feature macro: HILITE_EN (adds sel_row / sel_col).
//
// Modports:
//   master - the draw controller
//   slave  - the environment (game logic, board memory, drawer, VGA)
// ---------------------------------------------------------------------------
interface board_draw_ctrl_if;

  // request handshake
  logic        full_req;
  logic        cell_req;
  logic [3:0]  req_row;
  logic [3:0]  req_col;
  logic        req_ack;
  logic        busy;
  logic        done;

  // board memory read port
  logic [3:0]  rd_row;
  logic [3:0]  rd_col;
  logic [3:0]  rd_digit;

  // tile drawer
  logic        draw_enable;
  logic        draw_done;
  logic [5:0]  draw_x;
  logic [5:0]  draw_y;
  logic [15:0] draw_addr;

  // VGA plot bus
  logic        plot;
  logic [9:0]  vga_x;
  logic [8:0]  vga_y;
  logic [15:0] rom_addr;

`ifdef HILITE_EN
  // highlighted cell selection
  logic [3:0]  sel_row;
  logic [3:0]  sel_col;
`endif

  modport master (
`ifdef HILITE_EN
    input  sel_row,
    input  sel_col,
`endif
    input  full_req,
    input  cell_req,
    input  req_row,
    input  req_col,
    output req_ack,
    output busy,
    output done,
    output rd_row,
    output rd_col,
    input  rd_digit,
    output draw_enable,
    input  draw_done,
    input  draw_x,
    input  draw_y,
    input  draw_addr,
    output plot,
    output vga_x,
    output vga_y,
    output rom_addr
  );

  modport slave (
`ifdef HILITE_EN
    output sel_row,
    output sel_col,
`endif
    output full_req,
    output cell_req,
    output req_row,
    output req_col,
    input  req_ack,
    input  busy,
    input  done,
    input  rd_row,
    input  rd_col,
    output rd_digit,
    input  draw_enable,
    output draw_done,
    output draw_x,
    output draw_y,
    output draw_addr,
    input  plot,
    input  vga_x,
    input  vga_y,
    input  rom_addr
  );

endinterface

// File: rtl/board_draw_ctrl.sv
// ---------------------------------------------------------------------------
// board_draw_ctrl
//
// Walks the tile drawer over the 9x9 Sudoku grid. A job is either a full
// board redraw (81 tiles, row-major) or a single-cell redraw. For each cell
// the controller reads the digit from board memory, computes the cell's
// screen origin and the ROM bank of the digit's tile, enables the drawer for
// one tile, then drops the enable for one cycle so the drawer clears itself.
//
// Ports:
//   clk     system clock
//   resetn  asynchronous active-low reset
//   bus     board_draw_ctrl_if.master (request handshake, board-memory read,
//           tile-drawer control/status, VGA plot bus)
//
// Optional feature macro: HILITE_EN
//   When defined, the cell matching (sel_row, sel_col) uses the highlighted
//   tile set, i.e. the effective digit is digit+10 (ROM holds 20 tiles).
//   When undefined the sel inputs do not exist and digits are used as is.
//
// Timing notes:
//   - req_ack is asserted combinationally in IDLE while a request level is
//     present; the request is taken on that clock edge, so busy rises on the
//     cycle after req_ack.
//   - Board memory has one cycle of read latency: rd_row/rd_col are shown in
//     FETCH and rd_digit is captured at the end of LATCH.
//   - plot/vga_x/vga_y/rom_addr are combinational from the drawer's counters
//     during DRAW and zero in every other state.
// ---------------------------------------------------------------------------
module board_draw_ctrl #(
  parameter int CELL_W     = 47,
  parameter int CELL_H     = 52,
  parameter int ORG_X      = 0,
  parameter int ORG_Y      = 6,
  parameter int TILE_WORDS = 2444
) (
  input  logic              clk,
  input  logic              resetn,
  board_draw_ctrl_if.master bus
);

  // -------------------------------------------------------------------------
  // State encoding
  // -------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LATCH   = 3'd2;
  localparam logic [2:0] S_DRAW    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_NEXT    = 3'd5;

  localparam logic [3:0] LAST_IDX  = 4'd8;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [2:0]  state_reg,     state_next;
  logic [3:0]  row_reg,       row_next;
  logic [3:0]  col_reg,       col_next;
  logic        full_mode_reg, full_mode_next;
  logic [9:0]  base_x_reg,    base_x_next;
  logic [8:0]  base_y_reg,    base_y_next;
  logic [15:0] bank_reg,      bank_next;

  // -------------------------------------------------------------------------
  // Per-cell arithmetic (only consumed in LATCH)
  // -------------------------------------------------------------------------
  logic [4:0]  digit_eff;
  logic [9:0]  base_x_calc;
  logic [8:0]  base_y_calc;
  logic [15:0] bank_calc;
  logic        req_bad;
  logic        last_cell;

  // Out-of-range memory contents fall back to the blank tile.
  always_comb begin
    digit_eff = (bus.rd_digit > 4'd9) ? 5'd0 : {1'b0, bus.rd_digit};
`ifdef HILITE_EN
    // Highlighted tiles live in ROM banks 10..19.
    if ((row_reg == bus.sel_row) && (col_reg == bus.sel_col)) begin
      digit_eff = digit_eff + 5'd10;
    end
`endif
  end

  // Constant multiplies; the tools fold these into shift-add networks.
  assign base_x_calc = 10'(ORG_X) + 10'(col_reg) * 10'(CELL_W);
  assign base_y_calc = 9'(ORG_Y) + 9'(row_reg) * 9'(CELL_H);
  assign bank_calc   = 16'(digit_eff) * 16'(TILE_WORDS);

  assign req_bad   = (bus.req_row > LAST_IDX) || (bus.req_col > LAST_IDX);
  assign last_cell = (row_reg == LAST_IDX) && (col_reg == LAST_IDX);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    row_next       = row_reg;
    col_next       = col_reg;
    full_mode_next = full_mode_reg;
    base_x_next    = base_x_reg;
    base_y_next    = base_y_reg;
    bank_next      = bank_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.full_req) begin
          row_next       = 4'd0;
          col_next       = 4'd0;
          full_mode_next = 1'b1;
          state_next     = S_FETCH;
        end else if (bus.cell_req) begin
          full_mode_next = 1'b0;
          if (req_bad) begin
            // Acknowledge and finish without touching memory or the drawer;
            // the stored cell is left as is so rd_row/rd_col stay in range.
            state_next = S_NEXT;
          end else begin
            row_next   = bus.req_row;
            col_next   = bus.req_col;
            state_next = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        state_next = S_LATCH;
      end

      S_LATCH: begin
        // rd_digit is valid now; fold it straight into the ROM bank base.
        base_x_next = base_x_calc;
        base_y_next = base_y_calc;
        bank_next   = bank_calc;
        state_next  = S_DRAW;
      end

      S_DRAW: begin
        if (bus.draw_done) begin
          state_next = S_RELEASE;
        end
      end

      S_RELEASE: begin
        state_next = S_NEXT;
      end

      S_NEXT: begin
        if (!full_mode_reg || last_cell) begin
          state_next = S_IDLE;
        end else begin
          if (col_reg == LAST_IDX) begin
            col_next = 4'd0;
            row_next = row_reg + 4'd1;
          end else begin
            col_next = col_reg + 4'd1;
          end
          state_next = S_FETCH;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      row_reg       <= 4'd0;
      col_reg       <= 4'd0;
      full_mode_reg <= 1'b0;
      base_x_reg    <= 10'd0;
      base_y_reg    <= 9'd0;
      bank_reg      <= 16'd0;
    end else begin
      state_reg     <= state_next;
      row_reg       <= row_next;
      col_reg       <= col_next;
      full_mode_reg <= full_mode_next;
      base_x_reg    <= base_x_next;
      base_y_reg    <= base_y_next;
      bank_reg      <= bank_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // The reset term keeps req_ack low while reset is held even if a request
  // level is already present.
  assign bus.req_ack     = resetn && (state_reg == S_IDLE) &&
                           (bus.full_req || bus.cell_req);
  assign bus.busy        = (state_reg != S_IDLE);
  assign bus.done        = (state_reg == S_NEXT) && (!full_mode_reg || last_cell);
  assign bus.rd_row      = row_reg;
  assign bus.rd_col      = col_reg;
  assign bus.draw_enable = (state_reg == S_DRAW);

  always_comb begin
    bus.plot     = 1'b0;
    bus.vga_x    = 10'd0;
    bus.vga_y    = 9'd0;
    bus.rom_addr = 16'd0;
    if (state_reg == S_DRAW) begin
      // The draw_done cycle carries no pixel.
      bus.plot     = ~bus.draw_done;
      bus.vga_x    = base_x_reg + 10'(bus.draw_x);
      bus.vga_y    = base_y_reg + 9'(bus.draw_y);
      bus.rom_addr = bank_reg + bus.draw_addr;
    end
  end

endmodule

// File: tb/tb_board_draw_ctrl.sv
// ---------------------------------------------------------------------------
// tb_board_draw_ctrl
//
// Bench for board_draw_ctrl. Provides a board memory (one-cycle read
// latency), a behavioural tile drawer and a scoreboard that predicts every
// plotted pixel from the cell list of the running job.
// The drawer either sweeps the whole 47x52 tile or, to keep full-board jobs
// short, presents three representative pixels (origin, a random pixel and
// the far corner) before raising draw_done.
// ---------------------------------------------------------------------------
module tb_board_draw_ctrl;

  localparam int CELL_W     = 47;
  localparam int CELL_H     = 52;
  localparam int ORG_X      = 0;
  localparam int ORG_Y      = 6;
  localparam int TILE_WORDS = 2444;
  localparam int TILE_PIX   = CELL_W * CELL_H;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  board_draw_ctrl_if bus ();

  board_draw_ctrl #(
    .CELL_W     (CELL_W),
    .CELL_H     (CELL_H),
    .ORG_X      (ORG_X),
    .ORG_Y      (ORG_Y),
    .TILE_WORDS (TILE_WORDS)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Board memory model
  // -------------------------------------------------------------------------
  logic [3:0] board [0:8][0:8];
  int sel_r = 0;
  int sel_c = 0;

  always @(posedge clk) begin
    if (bus.rd_row < 4'd9 && bus.rd_col < 4'd9) bus.rd_digit <= board[bus.rd_row][bus.rd_col];
    else bus.rd_digit <= 4'd0;
  end

`ifdef HILITE_EN
  assign bus.sel_row = 4'(sel_r);
  assign bus.sel_col = 4'(sel_c);
`endif

  // -------------------------------------------------------------------------
  // Tile drawer model
  // -------------------------------------------------------------------------
  bit full_tile = 1'b0;
  int pi    = 0;
  int rnd_x = 10;
  int rnd_y = 20;
  int px, py;

  function automatic int npts();
    return full_tile ? TILE_PIX : 3;
  endfunction

  always @(posedge clk) begin
    if (!bus.draw_enable) begin
      pi            <= 0;
      bus.draw_done <= 1'b0;
      rnd_x         <= int'($urandom_range(0, CELL_W - 1));
      rnd_y         <= int'($urandom_range(0, CELL_H - 1));
    end else if (!bus.draw_done) begin
      if (pi == npts() - 1) bus.draw_done <= 1'b1;
      else                  pi <= pi + 1;
    end
  end

  always_comb begin
    px = 0;
    py = 0;
    if (full_tile) begin
      px = pi % CELL_W;
      py = pi / CELL_W;
    end else begin
      case (pi)
        0:       begin px = 0;          py = 0;          end
        1:       begin px = rnd_x;      py = rnd_y;      end
        default: begin px = CELL_W - 1; py = CELL_H - 1; end
      endcase
    end
  end

  // drawer ROM address counts pixels from a start offset of 2
  assign bus.draw_x    = 6'(px);
  assign bus.draw_y    = 6'(py);
  assign bus.draw_addr = 16'(py * CELL_W + px + 2);

  // -------------------------------------------------------------------------
  // Reference model / scoreboard
  // -------------------------------------------------------------------------
  typedef struct {
    int r;
    int c;
  } cell_t;

  cell_t exp_q[$];

  int   tile_idx   = 0;
  int   plot_cnt   = 0;
  int   en_tile    = 0;
  int   en_total   = 0;
  int   done_cnt   = 0;
  int   ack_cnt    = 0;
  logic prev_en    = 1'b0;
  int   first_x    = 0;
  int   first_y    = 0;
  int   first_addr = 0;

  task automatic check_pixel(input cell_t t);
    int d;
    d = int'(board[t.r][t.c]);
    if (d > 9) d = 0;
`ifdef HILITE_EN
    if (t.r == sel_r && t.c == sel_c) d = d + 10;
`endif
    check("vga_x", 32'(bus.vga_x), 32'(ORG_X + t.c * CELL_W + px));
    check("vga_y", 32'(bus.vga_y), 32'(ORG_Y + t.r * CELL_H + py));
    check("rom_addr", 32'(bus.rom_addr), 32'((d * TILE_WORDS + py * CELL_W + px + 2) % 65536));
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      // an aborted tile is dropped from the expectation
      tile_idx <= exp_q.size();
      plot_cnt <= 0;
      en_tile  <= 0;
      prev_en  <= 1'b0;
    end else begin
      if (bus.done)    done_cnt <= done_cnt + 1;
      if (bus.req_ack) ack_cnt  <= ack_cnt + 1;
      prev_en <= bus.draw_enable;
      if (bus.draw_enable) begin
        en_total <= en_total + 1;
        en_tile  <= en_tile + 1;
        if (bus.plot) begin
          plot_cnt <= plot_cnt + 1;
          if (plot_cnt == 0) begin
            first_x    <= int'(bus.vga_x);
            first_y    <= int'(bus.vga_y);
            first_addr <= int'(bus.rom_addr);
          end
          check("tile_in_job", 32'(tile_idx < exp_q.size()), 32'd1);
          if (tile_idx < exp_q.size()) check_pixel(exp_q[tile_idx]);
        end
      end else begin
        check("plot_low", 32'(bus.plot), 32'd0);
        if (prev_en) begin
          check("tile_plots", 32'(plot_cnt), 32'(npts()));
          check("plots_vs_enable", 32'(plot_cnt), 32'(en_tile - 1));
          tile_idx <= tile_idx + 1;
          plot_cnt <= 0;
          en_tile  <= 0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else tick();
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic randomize_board(input int max_digit);
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        board[r][c] = 4'($urandom_range(0, max_digit));
  endtask

  task automatic run_cell(input int r, input int c, input int budget);
    int  acks0, en0, dn0;
    bit  valid;
    cell_t t;
    acks0 = ack_cnt;
    en0   = en_total;
    dn0   = done_cnt;
    valid = (r < 9) && (c < 9);
    if (valid) begin
      t.r = r;
      t.c = c;
      exp_q.push_back(t);
    end
    tick();
    bus.req_row  = 4'(r);
    bus.req_col  = 4'(c);
    bus.cell_req = 1'b1;
    #1;
    check("cell_ack", 32'(bus.req_ack), 32'd1);
    check("cell_busy_pre", 32'(bus.busy), 32'd0);
    tick();
    bus.cell_req = 1'b0;
    #1;
    check("cell_ack_pulse", 32'(bus.req_ack), 32'd0);
    check("cell_busy", 32'(bus.busy), 32'd1);
    if (!valid) check("bad_cell_done_next", 32'(bus.done), 32'd1);
    wait_done("cell_done", budget);
    tick();
    check("cell_busy_after", 32'(bus.busy), 32'd0);
    check("cell_done_once", 32'(done_cnt - dn0), 32'd1);
    check("cell_ack_once", 32'(ack_cnt - acks0), 32'd1);
    check("cell_tiles", 32'(tile_idx), 32'(exp_q.size()));
    if (!valid) check("bad_cell_no_draw", 32'(en_total - en0), 32'd0);
    $display("cell job (%0d,%0d): tiles done %0d", r, c, tile_idx);
  endtask

  // Full-board job; with_cell also holds cell_req from the start so the
  // cell request must wait for the full job and then be accepted.
  task automatic run_full(input bit with_cell, input int r, input int c);
    int    acks0, dn0;
    cell_t t;
    acks0 = ack_cnt;
    dn0   = done_cnt;
    for (int rr = 0; rr < 9; rr++) begin
      for (int cc = 0; cc < 9; cc++) begin
        t.r = rr;
        t.c = cc;
        exp_q.push_back(t);
      end
    end
    if (with_cell) begin
      t.r = r;
      t.c = c;
      exp_q.push_back(t);
    end
    tick();
    bus.full_req = 1'b1;
    bus.cell_req = with_cell;
    bus.req_row  = 4'(r);
    bus.req_col  = 4'(c);
    #1;
    check("full_ack", 32'(bus.req_ack), 32'd1);
    tick();
    bus.full_req = 1'b0;
    #1;
    check("full_ack_pulse", 32'(bus.req_ack), 32'd0);
    check("full_busy", 32'(bus.busy), 32'd1);
    wait_done("full_done", 3000);
    check("full_acks_while_busy", 32'(ack_cnt - acks0), 32'd1);
    check("full_last_base_x", 32'(first_x), 32'd376);
    check("full_last_base_y", 32'(first_y), 32'd422);
    tick();
    check("full_busy_after", 32'(bus.busy), 32'd0);
    check("full_done_once", 32'(done_cnt - dn0), 32'd1);
    if (with_cell) begin
      check("prio_cell_ack", 32'(bus.req_ack), 32'd1);
      tick();
      bus.cell_req = 1'b0;
      #1;
      check("prio_cell_busy", 32'(bus.busy), 32'd1);
      wait_done("prio_cell_done", 100);
      tick();
      check("prio_acks", 32'(ack_cnt - acks0), 32'd2);
      check("prio_dones", 32'(done_cnt - dn0), 32'd2);
    end
    check("full_tiles", 32'(tile_idx), 32'(exp_q.size()));
    $display("full job (with_cell=%0d): tiles done %0d", with_cell, tile_idx);
  endtask

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    cell_t t;
    bus.full_req = 1'b0;
    bus.cell_req = 1'b0;
    bus.req_row  = 4'd0;
    bus.req_col  = 4'd0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        board[r][c] = 4'd0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_req_ack", 32'(bus.req_ack), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_draw_enable", 32'(bus.draw_enable), 32'd0);
    check("rst_plot", 32'(bus.plot), 32'd0);
    check("rst_rd_row", 32'(bus.rd_row), 32'd0);
    check("rst_rd_col", 32'(bus.rd_col), 32'd0);
    check("rst_vga_x", 32'(bus.vga_x), 32'd0);
    check("rst_vga_y", 32'(bus.vga_y), 32'd0);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    $display("reset state checked");
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // single cell (2,3), digit 5, full-length tile
    sel_r = 8;
    sel_c = 8;
    board[2][3] = 4'd5;
    full_tile = 1'b1;
    run_cell(2, 3, 3000);
    check("cell_first_x", 32'(first_x), 32'd141);
    check("cell_first_y", 32'(first_y), 32'd110);
    check("cell_first_addr", 32'(first_addr), 32'd12222);

    // full board, all blank
    full_tile = 1'b0;
    board[2][3] = 4'd0;
    run_full(1'b0, 0, 0);

    // full and cell together, random board incl. out-of-range digits
    randomize_board(15);
    sel_r = int'($urandom_range(0, 8));
    sel_c = int'($urandom_range(0, 8));
    run_full(1'b1, int'($urandom_range(0, 8)), int'($urandom_range(0, 8)));

    // out-of-range cell requests
    run_cell(9, 0, 10);
    run_cell(3, 12, 10);

    // random single cells
    for (int k = 0; k < 8; k++) begin
      randomize_board(15);
      sel_r = int'($urandom_range(0, 8));
      sel_c = int'($urandom_range(0, 8));
      run_cell(int'($urandom_range(0, 8)), int'($urandom_range(0, 8)), 100);
    end

`ifdef HILITE_EN
    // highlighted cell uses the second tile bank, neighbours do not
    sel_r = 4;
    sel_c = 4;
    board[4][4] = 4'd7;
    board[4][3] = 4'd7;
    run_cell(4, 4, 100);
    check("hilite_addr", 32'(first_addr), 32'(41548 + 2));
    run_cell(4, 3, 100);
    check("hilite_neighbour_addr", 32'(first_addr), 32'(17108 + 2));
`endif

    // reset in the middle of a tile draw
    full_tile = 1'b1;
    t.r = 5;
    t.c = 5;
    exp_q.push_back(t);
    tick();
    bus.req_row  = 4'd5;
    bus.req_col  = 4'd5;
    bus.cell_req = 1'b1;
    tick();
    bus.cell_req = 1'b0;
    repeat (100) tick();
    check("mid_draw_plot", 32'(bus.plot), 32'd1);
    resetn = 1'b0;
    #1;
    check("mid_rst_plot", 32'(bus.plot), 32'd0);
    check("mid_rst_draw_enable", 32'(bus.draw_enable), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_vga_x", 32'(bus.vga_x), 32'd0);
    check("mid_rst_vga_y", 32'(bus.vga_y), 32'd0);
    check("mid_rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("mid_rst_rd_row", 32'(bus.rd_row), 32'd0);
    repeat (2) tick();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_draw_enable", 32'(bus.draw_enable), 32'd0);
    end
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    $display("mid-draw reset checked");

    // a job still works after the abort
    full_tile = 1'b0;
    randomize_board(9);
    run_cell(8, 8, 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
